regfile_writer: RTL and testbench
=================================

Name: regfile_writer

Overview:
- Write side of the CPU's 32x32 general-purpose register file; the counterpart to the 5-bit-addressed 32-bit read selector.
- Holds the 32 architectural registers and takes one write per cycle from the WB stage.
- Exports the whole bank as a flat 1024-bit bus (register i at bits [i*32+31 : i*32]) for the read selectors.
- Keeps a per-register busy scoreboard (set at ID issue, cleared at WB) so the hazard unit can stall.

Parameters:
- WIDTH, 32, data width of one register.
- DEPTH, 32, number of registers; the address width is 5 bits, fixed.
- BYPASS, 1, when 1, a write in progress is visible on odata in the same cycle (write-through); when 0, it is visible only after the clock edge.

Ports:
- clk  input  1  system clock; every state change happens on its rising edge.
- rst  input  1  synchronous reset, active-high.
- we  input  1  write enable from the WB stage.
- waddr  input  5  destination register number for the write.
- wdata  input  32  data to write.
- issue_en  input  1  ID stage has issued an instruction that will write a register.
- issue_addr  input  5  destination register of that issued instruction.
- odata  output  1024  flattened register contents; register i is at bits [i*32+31 : i*32].
- busy  output  32  scoreboard; busy[i]=1 means a write to register i is still outstanding.
- wr_count  output  16  number of writes committed since reset; wraps.

Behaviour:
- Reset: on a rising edge with rst=1, all 32 registers, busy and wr_count go to 0.
  - rst overrides any we or issue_en in the same cycle; those are dropped.
  - After reset, odata is all zeros.
- Register 0:
  - Always reads as 0 and is never written.
  - busy[0] is always 0.
  - A write with waddr=0 is dropped and does not increment wr_count.
  - An issue with issue_addr=0 is ignored.
- Write:
  - On a rising edge with we=1 and waddr!=0: reg[waddr] <= wdata and wr_count <= wr_count+1 (16-bit wrap, 0xFFFF -> 0x0000).
  - The 5-to-32 one-hot decode of waddr, gated by we, selects the register. Exactly one register changes per cycle, never more.
- odata with BYPASS=0: purely the registered contents, one cycle of write latency.
- odata with BYPASS=1: while we=1 and waddr!=0, slice waddr of odata shows wdata combinationally in that same cycle; all other slices show registered values.
- Scoreboard, evaluated at each rising edge:
  - Issue only (issue_en=1, issue_addr=a, a!=0): busy[a] <= 1.
  - Writeback only (we=1, waddr=b, b!=0): busy[b] <= 0.
  - Both in the same cycle, a!=b: set a, clear b.
  - Both in the same cycle, a==b: busy[a] ends at 1. A new producer was issued, so the issue wins.
  - A writeback to a register whose busy bit is already 0 is legal: the data is written and busy stays 0.
  - An issue to a register that is already busy (WAW) keeps it at 1.
- There is no counting of multiple producers; a single busy bit per register is sufficient because the pipeline is in-order.
- No X propagation: every register bit has a defined reset value, and waddr/issue_addr values are ignored when their enable is 0.

Test Plan:
- Reset and initial state: assert rst for 2 cycles with we=1, waddr=5, wdata=0xFFFFFFFF -> odata=0, busy=0, wr_count=0 afterwards.
- Basic write: we=1, waddr=3, wdata=0xDEADBEEF for one edge, then we=0 -> odata[127:96]=0xDEADBEEF, all other slices 0, wr_count=1.
  - With BYPASS=1 the value also appears in the same cycle; with BYPASS=0 it appears only after the edge.
- Register 0 protection: we=1, waddr=0, wdata=0x12345678; issue_en=1, issue_addr=0 -> odata[31:0]=0, busy[0]=0, wr_count unchanged.
- Scoreboard sequence:
  - issue 7 -> busy=0x00000080.
  - issue 9 and writeback 7 in one cycle -> busy=0x00000200, reg7 updated.
  - issue 9 and writeback 9 together -> busy[9] stays 1.
- Sweep and wrap: write reg i = i*0x01010101 for i=1..31, then read back every slice.
  - Preload wr_count to near-wrap by 65535 dummy writes to reg 1, then one more write -> wr_count=0.
- Mid-operation reset: busy=0x0000FFFE and registers nonzero; assert rst on the same edge as we=1, waddr=4 -> all state 0, reg4 not written.

Source files
------------

// File: rtl/regfile_writer.sv
// 32x32 register file write side: one WB write per cycle, busy scoreboard, flat read bus.
// One edge of write latency (zero with BYPASS=1 write-through); no backpressure, always accepts.
module regfile_writer #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [4:0]               waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     issue_en,
  input  logic [4:0]               issue_addr,
  output logic [DEPTH*WIDTH-1:0]   odata,
  output logic [DEPTH-1:0]         busy,
  output logic [15:0]              wr_count
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] wsel;
  logic [DEPTH-1:0] isel;

  // One-hot selects with register 0 masked off, so it can never be written or marked busy.
  always_comb begin
    wsel = '0;
    isel = '0;
    if (we)       wsel[waddr]      = 1'b1;
    if (issue_en) isel[issue_addr] = 1'b1;
    wsel[0] = 1'b0;
    isel[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      wr_count <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wsel[i]) regs[i] <= wdata;
      end
      // Issue is applied after the clear so a same-register issue+writeback leaves the bit set.
      busy <= (busy & ~wsel) | isel;
      if (|wsel) wr_count <= wr_count + 16'd1;
    end
  end

  always_comb begin
    odata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((BYPASS != 0) && wsel[i]) odata[i*WIDTH +: WIDTH] = wdata;
      else                          odata[i*WIDTH +: WIDTH] = regs[i];
    end
  end

endmodule

// File: tb/tb_regfile_writer.sv
// Bench for regfile_writer: both BYPASS settings driven in parallel, checked every cycle
// against an array/bit-vector model, plus directed literal expectations.
module tb_regfile_writer;

  logic          clk = 1'b0;
  logic          rst, we, issue_en;
  logic [4:0]    waddr, issue_addr;
  logic [31:0]   wdata;
  logic [1023:0] odata1, odata0;
  logic [31:0]   busy1, busy0;
  logic [15:0]   cnt1, cnt0;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  logic [15:0] m_cnt;

  localparam logic [31:0] PAT = 32'h01010101;

  always #5 clk = ~clk;

  regfile_writer #(.WIDTH(32), .DEPTH(32), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .odata(odata1), .busy(busy1), .wr_count(cnt1));

  regfile_writer #(.WIDTH(32), .DEPTH(32), .BYPASS(0)) dut_reg (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .odata(odata0), .busy(busy0), .wr_count(cnt0));

  // Architectural model: what each edge must do to the register array, busy bits and counter.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) m_reg[k] = '0;
      m_busy = '0;
      m_cnt  = '0;
    end else begin
      if (we && waddr != 5'd0) begin
        m_reg[waddr]  = wdata;
        m_busy[waddr] = 1'b0;
        m_cnt         = m_cnt + 16'd1;
      end
      if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
    end
  end

  function automatic logic [1023:0] exp_od(bit byp);
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[k*32 +: 32] = m_reg[k];
    if (byp && we && waddr != 5'd0) v[waddr*32 +: 32] = wdata;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic chk_od(string name, logic [1023:0] got, logic [1023:0] exp);
    int first;
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      first = -1;
      for (int k = 31; k >= 0; k--) if (got[k*32 +: 32] !== exp[k*32 +: 32]) first = k;
      $display("FAIL %s: slice %0d got %h expected %h at %0t", name, first,
               got[first*32 +: 32], exp[first*32 +: 32], $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk_od("odata_bypass", odata1, exp_od(1'b1));
      chk_od("odata_registered", odata0, exp_od(1'b0));
      chk("busy_bypass", busy1, m_busy);
      chk("busy_registered", busy0, m_busy);
      chk("wr_count_bypass", {16'd0, cnt1}, {16'd0, m_cnt});
      chk("wr_count_registered", {16'd0, cnt0}, {16'd0, m_cnt});
    end
  end

  task automatic drive(bit r, bit w, logic [4:0] wa, logic [31:0] wd, bit ie, logic [4:0] ia);
    rst = r; we = w; waddr = wa; wdata = wd; issue_en = ie; issue_addr = ia;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
  endtask

  initial begin
    // Reset held two edges while a write is being attempted.
    drive(1'b1, 1'b1, 5'd5, 32'hFFFFFFFF, 1'b0, 5'd0);
    tick();
    cmp_en = 1'b1;
    tick();
    idle();
    chk_od("reset_odata", odata1, '0);
    chk("reset_busy", busy1, 32'd0);
    chk("reset_count", {16'd0, cnt1}, 32'd0);

    // Basic write, bypass visible before the edge, registered only after.
    drive(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0);
    #1;
    chk("bypass_same_cycle", odata1[127:96], 32'hDEADBEEF);
    chk("registered_same_cycle", odata0[127:96], 32'h0);
    tick();
    idle();
    chk("write_reg3", odata0[127:96], 32'hDEADBEEF);
    chk("write_reg2_untouched", odata0[95:64], 32'h0);
    chk("write_count", {16'd0, cnt0}, 32'd1);

    // Register 0 writes and issues are ignored.
    drive(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
    #1;
    chk("reg0_bypass", odata1[31:0], 32'h0);
    tick();
    idle();
    chk("reg0_value", odata0[31:0], 32'h0);
    chk("reg0_busy", busy0, 32'h0);
    chk("reg0_count", {16'd0, cnt0}, 32'd1);

    // Scoreboard sequence.
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    tick(); idle();
    chk("issue7", busy1, 32'h00000080);
    drive(1'b0, 1'b1, 5'd7, 32'hAAAA0007, 1'b1, 5'd9);
    tick(); idle();
    chk("issue9_wb7", busy1, 32'h00000200);
    chk("reg7_written", odata0[255:224], 32'hAAAA0007);
    drive(1'b0, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9);
    tick(); idle();
    chk("issue_wins", busy1, 32'h00000200);
    chk("reg9_written", odata0[319:288], 32'h99999999);
    chk("count_after_sb", {16'd0, cnt1}, 32'd3);

    // Sweep every register.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'(i) * PAT, 1'b0, 5'd0);
      tick();
    end
    idle();
    for (int i = 0; i < 32; i++) chk("sweep_slice", odata0[i*32 +: 32], 32'(i) * PAT);
    chk("sweep_busy", busy0, 32'h0);
    chk("sweep_count", {16'd0, cnt0}, 32'd34);

    // Counter wrap from a clean reset.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b0, 1'b1, 5'd1, 32'(i), 1'b0, 5'd0);
      tick();
    end
    idle();
    chk("count_ffff", {16'd0, cnt1}, 32'h0000FFFF);
    drive(1'b0, 1'b1, 5'd1, 32'h0BADF00D, 1'b0, 5'd0);
    tick(); idle();
    chk("count_wrap", {16'd0, cnt1}, 32'h0);
    chk("wrap_reg1", odata0[63:32], 32'h0BADF00D);

    // Mid-operation reset beats a simultaneous write and issue.
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b1, 5'(i + 16), 32'h1000 + 32'(i), 1'b1, 5'(i));
      tick();
    end
    idle();
    chk("busy_fffe", busy1, 32'h0000FFFE);
    chk("reg20_before_rst", odata0[671:640], 32'h1004);
    drive(1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 5'd6);
    tick(); idle();
    chk_od("midrst_odata_registered", odata0, '0);
    chk_od("midrst_odata_bypass", odata1, '0);
    chk("midrst_busy", busy0, 32'h0);
    chk("midrst_count", {16'd0, cnt0}, 32'h0);

    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
